// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op bit indices,
// FSM state encoding and the default datapath width.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  // Bit positions inside op_onehot = {MTLO,MTHI,DIVU,DIV,MULTU,MULT}
  localparam int OP_MULT  = 0;
  localparam int OP_MULTU = 1;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 3;
  localparam int OP_MTHI  = 4;
  localparam int OP_MTLO  = 5;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  // Malformed requests (no bit or several bits set) are dropped
  function automatic logic is_onehot6(input logic [5:0] v);
    return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// acc holds {upper, lower}: for multiply {partial product, multiplier},
// for divide {partial remainder, dividend/quotient}.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              mode_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_next,
  output logic              qbit
);

  logic [XLEN:0] sum;
  logic [XLEN:0] partial;
  logic [XLEN:0] diff;

  // Shift-add for multiply, restoring shift-subtract for divide; in divide
  // mode the LSB is left clear and the quotient bit is merged by the caller
  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    partial  = acc[2*XLEN-1:XLEN-1];
    diff     = partial - {1'b0, operand};
    qbit     = 1'b0;
    acc_next = {sum, acc[XLEN-1:1]};
    if (mode_div) begin
      qbit     = ~diff[XLEN];
      acc_next = {(qbit ? diff[XLEN-1:0] : partial[XLEN-1:0]), acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle multiply, IDLE->FIX).
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int ITER_CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [5:0]      op_onehot,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_t                state, state_nxt;
  logic [ITER_CNT_W-1:0] cnt;
  logic [2*XLEN-1:0]     acc, step_acc, prod_fix;
  logic [XLEN-1:0]       opb;
  logic                  is_div, neg_q, neg_r, step_q;

  logic                  accept, is_mul_op, is_div_op, sgn_a, sgn_b;
  logic [XLEN-1:0]       abs_a, abs_b, quo_fix, rem_fix;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .mode_div (is_div),
    .acc      (acc),
    .operand  (opb),
    .acc_next (step_acc),
    .qbit     (step_q)
  );

  assign busy = (state != IDLE);

  // Request decode, operand magnitudes and final sign correction
  always_comb begin
    accept    = (state == IDLE) && start && !flush && is_onehot6(op_onehot);
    is_mul_op = op_onehot[OP_MULT] | op_onehot[OP_MULTU];
    is_div_op = op_onehot[OP_DIV]  | op_onehot[OP_DIVU];
    sgn_a     = (op_onehot[OP_MULT] | op_onehot[OP_DIV]) & src_a[XLEN-1];
    sgn_b     = (op_onehot[OP_MULT] | op_onehot[OP_DIV]) & src_b[XLEN-1];
    abs_a     = sgn_a ? -src_a : src_a;
    abs_b     = sgn_b ? -src_b : src_b;
    prod_fix  = neg_q ? -acc : acc;
    quo_fix   = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix   = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state; flush squashes CALC/FIX and blocks a same-cycle start
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && is_div_op) state_nxt = CALC;
        if (accept && is_mul_op) begin
`ifdef MULDIV_FAST_MUL_EN
          state_nxt = FIX;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC: begin
        if (flush)                                    state_nxt = IDLE;
        else if (cnt == ITER_CNT_W'(XLEN - 1))        state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, iteration, HI/LO write-back and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == FIX) && !flush;
      case (state)
        IDLE: if (accept) begin
          if (op_onehot[OP_MTHI]) hi <= src_a;
          if (op_onehot[OP_MTLO]) lo <= src_a;
          if (is_mul_op || is_div_op) begin
            cnt    <= '0;
            acc    <= {{XLEN{1'b0}}, abs_a};
            opb    <= abs_b;
            is_div <= is_div_op;
            neg_q  <= sgn_a ^ sgn_b;
            neg_r  <= sgn_a;
`ifdef MULDIV_FAST_MUL_EN
            if (is_mul_op) acc <= {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
`endif
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          acc <= step_acc | {{(2*XLEN-1){1'b0}}, step_q};
        end
        FIX: if (!flush) begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*XLEN-1:XLEN];
            lo <= prod_fix[XLEN-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: expected HI/LO pairs are queued at
// request time and popped when done pulses.
module tb_muldiv_hilo_unit;

  localparam logic [5:0] MULT  = 6'b000001;
  localparam logic [5:0] MULTU = 6'b000010;
  localparam logic [5:0] DIV   = 6'b000100;
  localparam logic [5:0] DIVU  = 6'b001000;
  localparam logic [5:0] MTHI  = 6'b010000;
  localparam logic [5:0] MTLO  = 6'b100000;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [5:0]  op_onehot;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] sbq[$];

  muldiv_hilo_unit dut (
    .clk(clk), .rst(rst), .start(start), .op_onehot(op_onehot),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference {HI,LO} from plain SV arithmetic plus the architectural corner cases
  function automatic logic [63:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    logic [63:0] p;
    p = '0;
    if (op == MULT) p = longint'($signed(a)) * longint'($signed(b));
    else if (op == MULTU) p = {32'd0, a} * {32'd0, b};
    else if (op == DIV) begin
      if (b == 32'd0) begin
        r = a;
        q = a[31] ? 32'd1 : 32'hFFFF_FFFF;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
      p = {r, q};
    end else if (op == DIVU) begin
      if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
      else            p = {a % b, a / b};
    end
    return p;
  endfunction

  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    int lat, exp_lat;
    logic seen;
    logic [63:0] exp;
    exp_lat = (op == MULT || op == MULTU) ? MUL_LAT : DIV_LAT;
    sbq.push_back(model(op, a, b));
    start = 1'b1; op_onehot = op; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; op_onehot = '0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got %0b want 1", name, busy); end
    seen = 1'b0; lat = 0;
    for (int i = 1; i <= 100 && !seen; i++) begin
      if (done === 1'b1) begin seen = 1'b1; lat = i - 1; end
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s timeout got no done want done", name);
      void'(sbq.pop_front());
      return;
    end
    exp = sbq.pop_front();
    checks++;
    if (hi !== exp[63:32]) begin errors++; $display("FAIL %s hi got %h want %h", name, hi, exp[63:32]); end
    checks++;
    if (lo !== exp[31:0]) begin errors++; $display("FAIL %s lo got %h want %h", name, lo, exp[31:0]); end
    checks++;
    if (lat != exp_lat) begin errors++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %0b want 0", name, busy); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done_width got %0b want 0", name, done); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op_onehot = '0; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++; $display("FAIL multu_max_const got %h%h want fffffffe00000001", hi, lo);
    end
    run_op(MULT, 32'hFFFF_FFFD, 32'd5, "mult_neg_pos");
    run_op(MULT, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "mult_neg_neg");
    run_op(MULT, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
  endtask

  task automatic test_div();
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_m7_2_const got %h/%h want ffffffff/fffffffd", hi, lo);
    end
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    run_op(DIV, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    run_op(DIVU, 32'hFFFF_FFF0, 32'd7, "divu_big");
  endtask

  task automatic test_div_zero();
    run_op(DIVU, 32'd100, 32'd0, "divu_zero");
    run_op(DIV, 32'hFFFF_FFFB, 32'd0, "div_neg_zero");
  endtask

  task automatic test_mthi_flush();
    start = 1'b1; op_onehot = MTHI; src_a = 32'h1234;
    @(negedge clk);
    start = 1'b0; op_onehot = '0;
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi got %h want 1234", hi); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_ctrl got busy %0b done %0b want 0 0", busy, done); end
    start = 1'b1; op_onehot = MTLO; src_a = 32'h5678;
    @(negedge clk);
    start = 1'b0; op_onehot = '0;
    checks++; if (lo !== 32'h5678) begin errors++; $display("FAIL mtlo got %h want 5678", lo); end
    // two bits set: must be ignored
    start = 1'b1; op_onehot = MTHI | MTLO; src_a = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; op_onehot = '0;
    checks++; if (hi !== 32'h1234 || lo !== 32'h5678 || busy !== 1'b0) begin
      errors++; $display("FAIL bad_op got hi %h lo %h busy %0b want 1234 5678 0", hi, lo, busy);
    end
    // flush in IDLE beats a same-cycle start
    start = 1'b1; flush = 1'b1; op_onehot = MTHI; src_a = 32'hBEEF;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; op_onehot = '0;
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL idle_flush got %h want 1234", hi); end
    // flush in the 10th CALC cycle
    start = 1'b1; op_onehot = DIVU; src_a = 32'd999; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0; op_onehot = '0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %0b want 0", busy); end
    begin
      int pulses = 0;
      for (int i = 0; i < 40; i++) begin
        if (done === 1'b1) pulses++;
        @(negedge clk);
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL flush_done got %0d pulses want 0", pulses); end
    end
    checks++; if (hi !== 32'h1234 || lo !== 32'h5678) begin
      errors++; $display("FAIL flush_hilo got %h/%h want 00001234/00005678", hi, lo);
    end
    run_op(DIVU, 32'd999, 32'd4, "after_flush");
  endtask

  task automatic test_busy_rst();
    int lat;
    logic seen;
    logic [63:0] exp;
    sbq.push_back(model(DIVU, 32'd1000, 32'd7));
    start = 1'b1; op_onehot = DIVU; src_a = 32'd1000; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0; op_onehot = '0;
    seen = 1'b0; lat = 0;
    for (int i = 1; i <= 100 && !seen; i++) begin
      if (done === 1'b1) begin seen = 1'b1; lat = i - 1; end
      else begin
        if (i == 5) begin start = 1'b1; op_onehot = MULT; src_a = 32'd100; src_b = 32'd100; end
        else begin start = 1'b0; op_onehot = '0; end
        @(negedge clk);
      end
    end
    start = 1'b0; op_onehot = '0;
    checks++;
    if (!seen) begin
      errors++; $display("FAIL busy_start timeout got no done want done");
      void'(sbq.pop_front());
    end else begin
      exp = sbq.pop_front();
      if ({hi, lo} !== exp || lat != DIV_LAT) begin
        errors++; $display("FAIL busy_start got %h%h lat %0d want %h lat %0d", hi, lo, lat, exp, DIV_LAT);
      end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL busy_start_idle got busy %0b done %0b want 0 0", busy, done);
    end
    // async reset in the middle of CALC
    start = 1'b1; op_onehot = DIV; src_a = 32'd77; src_b = 32'd5;
    @(negedge clk);
    start = 1'b0; op_onehot = '0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL async_rst_hilo got %h/%h want 0/0", hi, lo); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL async_rst_ctrl got busy %0b done %0b want 0 0", busy, done); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(DIV, 32'd77, 32'hFFFF_FFFB, "after_rst");
  endtask

  task automatic test_random();
    logic [5:0] ops [4];
    ops[0] = MULT; ops[1] = MULTU; ops[2] = DIV; ops[3] = DIVU;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[$urandom_range(3, 0)], $urandom, (i == 3) ? 32'd0 : $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_mthi_flush();
    test_busy_rst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
